// File: rtl/bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_responder_pkg
// Description : Shared types and constants for the bus_responder block:
//               responder FSM states, decoded CPU cycle type and the width
//               of the wait-state counter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_responder_pkg;

  // Width of the wait-state counter (WAIT_MIN range 0..15)
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CYC_NONE = 2'd0,
    CYC_MEM  = 2'd1,
    CYC_IO   = 2'd2
  } cyc_t;

endpackage : bus_responder_pkg
`default_nettype wire

// File: rtl/bus_window_decode.sv
`default_nettype none
// ============================================================================
// Module      : bus_window_decode
// Description : Combinational CPU bus-cycle classifier and window hit check.
//               Refresh and interrupt-acknowledge cycles are never reported.
// Ports       : i_address[15:0]          CPU address pins
//               i_nmreq/i_niorq/i_nrd/
//               i_nwr/i_nm1/i_nrfsh      CPU control strobes (active-low)
//               o_cyc                    decoded cycle type
//               o_hit                    cycle falls inside its window
// Revision    : 1.0 - initial release
// ============================================================================
module bus_window_decode
  import bus_responder_pkg::*;
#(
  parameter logic [15:0] MEM_BASE = 16'h0000,
  parameter logic [15:0] MEM_MASK = 16'hC000,
  parameter logic [7:0]  IO_BASE  = 8'h10,
  parameter logic [7:0]  IO_MASK  = 8'hF0
) (
  input  logic [15:0] i_address,
  input  logic        i_nmreq,
  input  logic        i_niorq,
  input  logic        i_nrd,
  input  logic        i_nwr,
  input  logic        i_nm1,
  input  logic        i_nrfsh,
  output cyc_t        o_cyc,
  output logic        o_hit
);

  logic w_strobe;
  logic w_mem_cyc;
  logic w_io_cyc;
  logic w_mem_win;
  logic w_io_win;

  assign w_strobe  = !i_nrd || !i_nwr;
  assign w_mem_cyc = !i_nmreq && i_nrfsh && w_strobe;
  // nM1 low together with nIORQ low is an interrupt acknowledge, not I/O
  assign w_io_cyc  = !i_niorq && i_nm1 && w_strobe;

  assign w_mem_win = ((i_address & MEM_MASK) == (MEM_BASE & MEM_MASK));
  assign w_io_win  = ((i_address[7:0] & IO_MASK) == (IO_BASE & IO_MASK));

  always_comb begin
    o_cyc = CYC_NONE;
    if (w_mem_cyc) begin
      o_cyc = CYC_MEM;
    end else if (w_io_cyc) begin
      o_cyc = CYC_IO;
    end
  end

  // Hit is tied to the reported cycle type so the two never disagree
  assign o_hit = ((o_cyc == CYC_MEM) && w_mem_win) ||
                 ((o_cyc == CYC_IO)  && w_io_win);

endmodule : bus_window_decode
`default_nettype wire

// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_responder
// Description : CPU-bus target. Claims memory / I/O window hits, forwards
//               them to a req/ack backing store, stretches the CPU cycle with
//               nWAIT and returns read data on the CPU data pins.
// Ports       : clk, reset            clock, synchronous active-high reset
//               address, n* strobes   CPU bus inputs
//               data_in               CPU write data
//               data_out, data_oe     read data and its drive enable
//               nWAIT                 wait request (active-low)
//               be_*                  backing-store request/response
// Options     : BUS_RESPONDER_M1_WAIT_EN - one extra wait state on every
//               opcode fetch (MEM read with nM1 low)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter logic [15:0] MEM_BASE = 16'h0000,
  parameter logic [15:0] MEM_MASK = 16'hC000,
  parameter logic [7:0]  IO_BASE  = 8'h10,
  parameter logic [7:0]  IO_MASK  = 8'hF0,
  parameter int          WAIT_MIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  input  logic        nRFSH,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        nWAIT,
  output logic        be_req,
  output logic        be_we,
  output logic        be_io,
  output logic [15:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic [7:0]  be_rdata,
  input  logic        be_ack
);

  localparam logic [WAIT_W-1:0] c_wait_min = WAIT_W'(WAIT_MIN);

  cyc_t              w_cyc;
  logic              w_hit;
  logic              w_release;
  logic [WAIT_W-1:0] w_cnt_load;

  state_t            r_state,    w_state_nxt;
  logic [WAIT_W-1:0] r_cnt,      w_cnt_nxt;
  logic              r_ack_seen, w_ack_seen_nxt;
  logic [7:0]        r_data_out, w_data_out_nxt;
  logic              r_data_oe,  w_data_oe_nxt;
  logic              r_nwait,    w_nwait_nxt;
  logic              r_be_req,   w_be_req_nxt;
  logic              r_be_we,    w_be_we_nxt;
  logic              r_be_io,    w_be_io_nxt;
  logic [15:0]       r_be_addr,  w_be_addr_nxt;
  logic [7:0]        r_be_wdata, w_be_wdata_nxt;

  bus_window_decode #(
    .MEM_BASE (MEM_BASE),
    .MEM_MASK (MEM_MASK),
    .IO_BASE  (IO_BASE),
    .IO_MASK  (IO_MASK)
  ) u_decode (
    .i_address (address),
    .i_nmreq   (nMREQ),
    .i_niorq   (nIORQ),
    .i_nrd     (nRD),
    .i_nwr     (nWR),
    .i_nm1     (nM1),
    .i_nrfsh   (nRFSH),
    .o_cyc     (w_cyc),
    .o_hit     (w_hit)
  );

  // CPU has ended the bus cycle: no data strobe or no space strobe left
  assign w_release = (nRD && nWR) || (nMREQ && nIORQ);

`ifdef BUS_RESPONDER_M1_WAIT_EN
  logic            w_fetch;
  logic [WAIT_W:0] w_load_ext;
  assign w_fetch    = (w_cyc == CYC_MEM) && !nRD && !nM1;
  assign w_load_ext = {1'b0, c_wait_min} + {{WAIT_W{1'b0}}, w_fetch};
  // Saturate rather than wrap when WAIT_MIN is already at full scale
  assign w_cnt_load = w_load_ext[WAIT_W] ? {WAIT_W{1'b1}} : w_load_ext[WAIT_W-1:0];
`else
  assign w_cnt_load = c_wait_min;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ack_seen_nxt = r_ack_seen;
    w_data_out_nxt = r_data_out;
    w_data_oe_nxt  = r_data_oe;
    w_nwait_nxt    = r_nwait;
    w_be_req_nxt   = r_be_req;
    w_be_we_nxt    = r_be_we;
    w_be_io_nxt    = r_be_io;
    w_be_addr_nxt  = r_be_addr;
    w_be_wdata_nxt = r_be_wdata;

    case (r_state)
      IDLE: begin
        w_data_oe_nxt = 1'b0;
        w_nwait_nxt   = 1'b1;
        if (w_hit) begin
          w_state_nxt    = ACCESS;
          w_be_req_nxt   = 1'b1;
          w_nwait_nxt    = 1'b0;
          w_cnt_nxt      = w_cnt_load;
          w_ack_seen_nxt = 1'b0;
          w_be_addr_nxt  = address;
          w_be_we_nxt    = !nWR;
          w_be_io_nxt    = (w_cyc == CYC_IO);
          w_be_wdata_nxt = data_in;
        end
      end

      ACCESS: begin
        w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
        if (be_ack && r_be_req) begin
          w_ack_seen_nxt = 1'b1;
          w_be_req_nxt   = 1'b0;
          if (!r_be_we) begin
            w_data_out_nxt = be_rdata;
          end
        end
        // Completion uses the registered ack flag, so nWAIT rises one edge
        // after both the ack and the minimum wait count have been reached.
        if (w_release) begin
          w_state_nxt = DRAIN;
          w_nwait_nxt = 1'b1;
        end else if (r_ack_seen && (r_cnt == '0)) begin
          w_state_nxt   = DONE;
          w_nwait_nxt   = 1'b1;
          w_data_oe_nxt = !r_be_we;
        end
      end

      DONE: begin
        w_nwait_nxt = 1'b1;
        if (w_release) begin
          w_state_nxt   = IDLE;
          w_data_oe_nxt = 1'b0;
        end
      end

      DRAIN: begin
        // Aborted cycle: finish the backing-store handshake without data
        w_nwait_nxt   = 1'b1;
        w_data_oe_nxt = 1'b0;
        if (r_ack_seen) begin
          w_state_nxt = IDLE;
        end else if (be_ack && r_be_req) begin
          w_ack_seen_nxt = 1'b1;
          w_be_req_nxt   = 1'b0;
          w_state_nxt    = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ack_seen <= 1'b0;
      r_data_out <= 8'h00;
      r_data_oe  <= 1'b0;
      r_nwait    <= 1'b1;
      r_be_req   <= 1'b0;
      r_be_we    <= 1'b0;
      r_be_io    <= 1'b0;
      r_be_addr  <= 16'h0000;
      r_be_wdata <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ack_seen <= w_ack_seen_nxt;
      r_data_out <= w_data_out_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_nwait    <= w_nwait_nxt;
      r_be_req   <= w_be_req_nxt;
      r_be_we    <= w_be_we_nxt;
      r_be_io    <= w_be_io_nxt;
      r_be_addr  <= w_be_addr_nxt;
      r_be_wdata <= w_be_wdata_nxt;
    end
  end

  assign data_out = r_data_out;
  assign data_oe  = r_data_oe;
  assign nWAIT    = r_nwait;
  assign be_req   = r_be_req;
  assign be_we    = r_be_we;
  assign be_io    = r_be_io;
  assign be_addr  = r_be_addr;
  assign be_wdata = r_be_wdata;

endmodule : bus_responder
`default_nettype wire

// File: tb/tb_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_responder
// Description : Directed self-checking bench for bus_responder. Three
//               instances share the CPU-side stimulus and differ only in
//               WAIT_MIN (index 0: 1, index 1: 3, index 2: 0).
// Options     : BUS_RESPONDER_M1_WAIT_EN changes the expected fetch timing
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        nMREQ, nIORQ, nRD, nWR, nM1, nRFSH;
  logic [7:0]  data_in;
  logic [7:0]  be_rdata;
  logic        be_ack;

  logic [7:0]  dout_v  [3];
  logic [15:0] addr_v  [3];
  logic [7:0]  wdata_v [3];
  logic [2:0]  oe_v, nwait_v, req_v, we_v, io_v;

  int n_checks = 0;
  int n_errors = 0;

  // Snapshot of one bus transaction
  int          s_low;
  logic        s_done;
  logic        s_req, s_we, s_io, s_oe, s_oe_after;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata, s_dout;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WM = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    bus_responder #(.WAIT_MIN(WM)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .address  (address),
      .nMREQ    (nMREQ),
      .nIORQ    (nIORQ),
      .nRD      (nRD),
      .nWR      (nWR),
      .nM1      (nM1),
      .nRFSH    (nRFSH),
      .data_in  (data_in),
      .data_out (dout_v[g]),
      .data_oe  (oe_v[g]),
      .nWAIT    (nwait_v[g]),
      .be_req   (req_v[g]),
      .be_we    (we_v[g]),
      .be_io    (io_v[g]),
      .be_addr  (addr_v[g]),
      .be_wdata (wdata_v[g]),
      .be_rdata (be_rdata),
      .be_ack   (be_ack)
    );
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    address = 16'h0000;
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    nM1 = 1'b1; nRFSH = 1'b1;
    data_in = 8'h00;
    be_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_bus();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // kind: 0 = MEM, 1 = IO, 2 = refresh, 3 = interrupt acknowledge.
  // ack_lat: edge (counted from the claiming edge) at which be_ack is sampled.
  task automatic run_cycle(input int sel, input logic [15:0] addr, input int kind,
                           input logic wr, input logic m1, input logic [7:0] wd,
                           input logic [7:0] rd, input int ack_lat);
    @(negedge clk);
    address  = addr;
    data_in  = wd;
    be_rdata = rd;
    nRD      = wr;
    nWR      = !wr;
    case (kind)
      0:       nMREQ = 1'b0;
      1:       nIORQ = 1'b0;
      2:       begin nMREQ = 1'b0; nRFSH = 1'b0; end
      default: begin nIORQ = 1'b0; nM1 = 1'b0; end
    endcase
    if (m1) nM1 = 1'b0;
    @(posedge clk);
    s_low  = 0;
    s_done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        s_req   = req_v[sel];
        s_addr  = addr_v[sel];
        s_we    = we_v[sel];
        s_io    = io_v[sel];
        s_wdata = wdata_v[sel];
      end
      if (nwait_v[sel]) begin
        s_done = 1'b1;
        break;
      end
      s_low++;
      be_ack = (k == ack_lat);
    end
    be_ack = 1'b0;
    check_val("nwait_release_in_time", s_done, 1'b1);
    s_oe   = oe_v[sel];
    s_dout = dout_v[sel];
    idle_bus();
    @(negedge clk);
    s_oe_after = oe_v[sel];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    be_rdata = 8'h00;
    idle_bus();
    repeat (2) @(negedge clk);
    check_val("rst_data_out", dout_v[0], 8'h00);
    check_val("rst_data_oe",  oe_v[0],   1'b0);
    check_val("rst_nwait",    nwait_v[0], 1'b1);
    check_val("rst_be_req",   req_v[0],  1'b0);
    check_val("rst_be_addr",  addr_v[0], 16'h0000);
    reset = 1'b0;

    // MEM read 0x1234, WAIT_MIN=1, ack one cycle after request
    do_reset();
    run_cycle(0, 16'h1234, 0, 1'b0, 1'b0, 8'h00, 8'hA5, 1);
    check_val("rd_req",      s_req,  1'b1);
    check_val("rd_addr",     s_addr, 16'h1234);
    check_val("rd_we",       s_we,   1'b0);
    check_val("rd_io",       s_io,   1'b0);
    check_val("rd_wait",     s_low,  2);
    check_val("rd_oe",       s_oe,   1'b1);
    check_val("rd_data",     s_dout, 8'hA5);
    check_val("rd_oe_after", s_oe_after, 1'b0);

    // IO write inside window
    do_reset();
    run_cycle(0, 16'h3417, 1, 1'b1, 1'b0, 8'h5A, 8'h00, 1);
    check_val("iow_req",   s_req,   1'b1);
    check_val("iow_io",    s_io,    1'b1);
    check_val("iow_we",    s_we,    1'b1);
    check_val("iow_addr",  s_addr,  16'h3417);
    check_val("iow_wdata", s_wdata, 8'h5A);
    check_val("iow_wait",  s_low,   2);
    check_val("iow_oe",    s_oe,    1'b0);

    // Misses: IO outside window, MEM outside window, refresh, int-ack
    do_reset();
    run_cycle(0, 16'h3427, 1, 1'b1, 1'b0, 8'h11, 8'h00, 1);
    check_val("iomiss_req",  s_req, 1'b0);
    check_val("iomiss_wait", s_low, 0);
    run_cycle(0, 16'h4000, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1);
    check_val("memmiss_req",  s_req, 1'b0);
    check_val("memmiss_wait", s_low, 0);
    run_cycle(0, 16'h0010, 2, 1'b0, 1'b0, 8'h00, 8'h00, 1);
    check_val("rfsh_req",  s_req, 1'b0);
    check_val("rfsh_wait", s_low, 0);
    run_cycle(0, 16'h0010, 3, 1'b0, 1'b0, 8'h00, 8'h00, 1);
    check_val("inta_req",  s_req, 1'b0);
    check_val("inta_wait", s_low, 0);

    // Wait-state timing: max(WAIT_MIN, ack latency) + 1
    do_reset();
    run_cycle(1, 16'h0040, 0, 1'b0, 1'b0, 8'h00, 8'h3E, 1);
    check_val("w3_wait", s_low,  4);
    check_val("w3_data", s_dout, 8'h3E);
    do_reset();
    run_cycle(2, 16'h0041, 0, 1'b0, 1'b0, 8'h00, 8'hC7, 5);
    check_val("w0_wait", s_low,  6);
    check_val("w0_data", s_dout, 8'hC7);
    do_reset();
    run_cycle(0, 16'h0042, 0, 1'b0, 1'b0, 8'h00, 8'h99, 3);
    check_val("w1_late_wait", s_low, 4);

    // Reset while in ACCESS, then a normal read
    do_reset();
    @(negedge clk);
    address = 16'h0100; nMREQ = 1'b0; nRD = 1'b0;
    @(negedge clk);
    check_val("mid_req_before",   req_v[0],   1'b1);
    check_val("mid_nwait_before", nwait_v[0], 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_rst_req",   req_v[0],   1'b0);
    check_val("mid_rst_nwait", nwait_v[0], 1'b1);
    check_val("mid_rst_oe",    oe_v[0],    1'b0);
    reset = 1'b0;
    idle_bus();
    run_cycle(0, 16'h0001, 0, 1'b0, 1'b0, 8'h00, 8'h3C, 1);
    check_val("post_rst_addr", s_addr, 16'h0001);
    check_val("post_rst_wait", s_low,  2);
    check_val("post_rst_data", s_dout, 8'h3C);

    // Abort: strobes released in ACCESS before ack
    do_reset();
    @(negedge clk);
    address = 16'h0200; nMREQ = 1'b0; nRD = 1'b0;
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    check_val("drain_req",   req_v[0],   1'b1);
    check_val("drain_nwait", nwait_v[0], 1'b1);
    check_val("drain_oe",    oe_v[0],    1'b0);
    be_ack = 1'b1;
    @(negedge clk);
    be_ack = 1'b0;
    check_val("drain_req_drop", req_v[0], 1'b0);

    // Opcode fetch at 0x0000, WAIT_MIN=1, immediate ack
    do_reset();
    run_cycle(0, 16'h0000, 0, 1'b0, 1'b1, 8'h00, 8'hED, 1);
`ifdef BUS_RESPONDER_M1_WAIT_EN
    check_val("m1_wait", s_low, 3);
`else
    check_val("m1_wait", s_low, 2);
`endif
    check_val("m1_data", s_dout, 8'hED);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bus_responder
`default_nettype wire

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- External-side target for the CPU address/control pins: the far end of the address latch and pin mux.
- Decodes the CPU bus cycle from address[15:0] and nMREQ/nIORQ/nRD/nWR/nM1/nRFSH, and claims hits in a memory window or an I/O window.
- Forwards each claimed cycle to a simple req/ack backing store. Holds nWAIT low until the data is ready, then drives read data back onto the CPU data pins.
- Used by the system-level benches and FPGA top as a memory/IO model with realistic wait states.

Parameters:
- MEM_BASE, 16'h0000: memory window base.
- MEM_MASK, 16'hC000: address bits compared for a memory hit. The default gives a 16 KB window.
- IO_BASE, 8'h10: I/O window base, compared against address[7:0].
- IO_MASK, 8'hF0: I/O bits compared.
- WAIT_MIN, 1: minimum wait states inserted per claimed cycle (0..15).

Ports:
- clk in 1: system clock; CPU T-clock domain.
- reset in 1: synchronous reset, active-high.
- address in 16: CPU address pins.
- nMREQ, nIORQ, nRD, nWR, nM1, nRFSH in 1 each: CPU control strobes, active-low, synchronous to clk.
- data_in in 8: CPU data pins, used for write data.
- data_out out 8: read data toward the CPU.
- data_oe out 1: data_out drive enable.
- nWAIT out 1: wait request to the CPU, active-low.
- be_req out 1: backing-store request.
- be_we out 1: 1 = write.
- be_io out 1: 1 = I/O space.
- be_addr out 16: latched address. In I/O cycles the upper byte is passed through.
- be_wdata out 8: latched write data.
- be_rdata in 8: backing-store read data, valid with be_ack.
- be_ack in 1: single-cycle acknowledge.

Behaviour:
- Reset values: data_out=0, data_oe=0, nWAIT=1, be_req=0, be_we=0, be_io=0, be_addr=0, be_wdata=0, state=IDLE, wait counter=0.
- Cycle types:
  - MEM: !nMREQ & nRFSH & (!nRD | !nWR).
  - IO: !nIORQ & nM1 & (!nRD | !nWR).
  - Refresh (!nRFSH) and interrupt acknowledge (!nIORQ & !nM1) are never claimed.
- Hit rules:
  - MEM hit: (address & MEM_MASK) == (MEM_BASE & MEM_MASK).
  - IO hit: (address[7:0] & IO_MASK) == (IO_BASE & IO_MASK).
- FSM states: IDLE, ACCESS, DONE, DRAIN.
- IDLE:
  - When a hit is sampled at edge N, latch address, we=!nWR, io and data_in.
  - At N+1: state=ACCESS, be_req=1, nWAIT=0, counter=WAIT_MIN (+1 if M1 extension applies).
- ACCESS:
  - Counter decrements each cycle and saturates at 0.
  - be_req holds 1 until be_ack is sampled. It drops on the edge where be_ack is seen.
  - On be_ack: capture be_rdata if reading.
  - Exit to DONE on the first edge where both ack-seen and counter==0 hold. The two may happen in either order.
  - Latency: nWAIT rises at max(WAIT_MIN, ack latency)+1 cycles after start.
- DONE:
  - nWAIT=1.
  - Reads: data_oe=1, data_out=captured data.
  - Writes: data_oe=0.
  - Stay until (nRD & nWR) or (nMREQ & nIORQ); then IDLE and data_oe=0 on the next edge.
- DRAIN (abort):
  - Entered if the strobes are released while in ACCESS.
  - Keep be_req until be_ack, never drive data_oe, nWAIT=1, then IDLE.
- New cycles are only detected in IDLE. A back-to-back cycle that starts during DONE is detected one edge after the return to IDLE.
- Reset mid-operation: everything returns to the reset values on the next edge. be_req drops even without ack; the backing store must tolerate this.
- A be_ack outside ACCESS/DRAIN is ignored.

Optional Feature:
- Macro: BUS_RESPONDER_M1_WAIT_EN.
- Defined: a MEM read with !nM1 (opcode fetch) loads counter=WAIT_MIN+1, giving one extra wait state on every fetch.
- Undefined: M1 fetches are timed like any other memory read. nM1 is used only for interrupt-acknowledge exclusion.

Decomposition:
- Package bus_responder_pkg:
  - state enum (IDLE, ACCESS, DONE, DRAIN);
  - cycle-type enum (CYC_NONE, CYC_MEM, CYC_IO);
  - constant WAIT_W=4.
- Sub-module bus_window_decode: combinational classification plus hit, parameterised by MEM_BASE/MEM_MASK/IO_BASE/IO_MASK.

Test Plan:
- MEM read at 16'h1234, WAIT_MIN=1, be_ack one cycle after be_req with be_rdata=8'hA5 -> be_addr=16'h1234, be_we=0, nWAIT low for exactly 2 cycles, then data_oe=1 and data_out=8'hA5 until nRD rises.
- IO write to 16'h3417, data_in=8'h5A -> be_io=1, be_we=1, be_wdata=8'h5A, data_oe stays 0. IO write to 16'h3427 -> no be_req, nWAIT stays 1.
- MEM read at 16'h4000 (outside window) and a refresh cycle at 16'h0010 -> no be_req, nWAIT=1 throughout.
- WAIT_MIN=3 with be_ack on the first request cycle -> nWAIT low 4 cycles. WAIT_MIN=0 with be_ack delayed 5 cycles -> nWAIT low 6 cycles.
- Assert reset while in ACCESS -> next edge: be_req=0, nWAIT=1, data_oe=0, state IDLE. A later read at 16'h0001 completes normally.
- With BUS_RESPONDER_M1_WAIT_EN, opcode fetch at 16'h0000, WAIT_MIN=1, immediate ack -> nWAIT low 3 cycles. Without the macro -> 2 cycles.
